// File: rtl/adc_pkg.sv
// Shared constants, capture FSM states and m_data field layout for the SAR ADC
// capture path. The controller and the packetiser use the same field offsets.
package adc_pkg;

  localparam int DATA_W      = 10;
  localparam int CONV_CYCLES = 12;
  localparam int NUM_CH      = 8;
  localparam int CH_W        = $clog2(NUM_CH);
  localparam int FIFO_DEPTH  = 8;
  localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } cap_state_e;

  // m_data = {ch_err, ch_idx, result}
  localparam int RESULT_LSB = 0;
  localparam int CH_LSB     = DATA_W;
  localparam int ERR_BIT    = DATA_W + CH_W;
  localparam int M_DATA_W   = DATA_W + CH_W + 1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push while full is accepted only
// when a pop happens in the same cycle; the caller decides what a refused push
// means. Occupancy is tracked in its own counter so pointers can wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign rd_en    = pop & ~empty;
  assign wr_en    = push & (~full | rd_en);
  // Head word is presented directly; zero while empty so the output is defined
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sar_adc_capture.sv
// SAR ADC capture: deserialises the comparator bit stream after each controller
// start pulse, tags it with the channel selected at start and queues the tagged
// word in a FWFT FIFO with a valid/ready output.
//
// Output handshake: m_valid is high whenever the FIFO head holds a word and
// m_data is that word; a word transfers on any clock edge where m_valid and
// m_ready are both high; while m_valid & ~m_ready, m_valid and m_data hold.
module sar_adc_capture #(
  parameter int DATA_W      = adc_pkg::DATA_W,
  parameter int CONV_CYCLES = adc_pkg::CONV_CYCLES,
  parameter int NUM_CH      = adc_pkg::NUM_CH,
  parameter int FIFO_DEPTH  = adc_pkg::FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   capture_en,
  input  logic                                   start,
  input  logic [NUM_CH-1:0]                      ch_sel,
  input  logic                                   adc_dout,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [DATA_W+$clog2(NUM_CH):0]         m_data,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
  output logic                                   overflow,
  output logic                                   abort_err,
  input  logic                                   err_clr,
  output adc_pkg::cap_state_e                    state_dbg
);

  import adc_pkg::*;

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WORD_W = DATA_W + CH_W + 1;

  // The controller's start period must leave room for the shift and push cycles
  if (DATA_W + 2 > CONV_CYCLES) begin : g_bad_cfg
    $error("sar_adc_capture: DATA_W+2 must not exceed CONV_CYCLES");
  end

  cap_state_e        state;
  cap_state_e        state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [CH_W-1:0]   ch_idx;
  logic              ch_err;
  logic [CH_W-1:0]   enc_idx;
  logic [CH_W:0]     enc_ones;
  logic              enc_err;
  logic              start_conv;
  logic              latch_ch;
  logic              shift_en;
  logic              do_push;
  logic              abort_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  assign start_conv = start & capture_en;
  assign state_dbg  = state;
  assign m_valid    = ~fifo_empty;
  assign pop        = m_valid & m_ready;
  assign drop       = do_push & fifo_full & ~pop;

  // Lowest set ch_sel bit wins; anything but exactly one set bit is flagged
  always_comb begin
    enc_idx  = '0;
    enc_ones = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_sel[i]) enc_idx = CH_W'(i);
      enc_ones = enc_ones + (CH_W + 1)'(ch_sel[i]);
    end
    enc_err = (enc_ones != (CH_W + 1)'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and datapath controls; a start is honoured in every state
  always_comb begin
    state_next = state;
    latch_ch   = start_conv;
    shift_en   = 1'b0;
    do_push    = 1'b0;
    abort_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start_conv) state_next = SHIFT;
      end
      SHIFT: begin
        if (start_conv) begin
          abort_set  = 1'b1;
          state_next = SHIFT;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) state_next = PUSH;
        end
      end
      PUSH: begin
        do_push    = 1'b1;
        state_next = start_conv ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel tag latch, bit counter and MSB-first shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      ch_idx  <= '0;
      ch_err  <= 1'b0;
    end else if (latch_ch) begin
      bit_cnt <= '0;
      ch_idx  <= enc_idx;
      ch_err  <= enc_err;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
      shreg   <= {shreg[DATA_W-2:0], adc_dout};
    end
  end

  // Sticky error flags; a clear beats a same-cycle set
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      overflow  <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      overflow  <= overflow | drop;
      abort_err <= abort_err | abort_set;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .push_data ({ch_err, ch_idx, shreg}),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule
